// File: rtl/fractal_sync_cc_mp.sv
// rtl/fractal_sync_cc_mp.sv - fractal sync core-control node with N child ports
//
// Collects barrier requests from N_PORTS children, tracks per-id arrivals in a
// direct-indexed register file, and either wakes the children locally (level 1)
// or forwards one aggregated request to the parent. Parent wakes are broadcast.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           per-port child request handshake
//   req_lvl_i/req_id_i                per-port packed level / barrier id
//   rsp_valid_o/rsp_id_o              wake pulse broadcast to all children
//   up_req_valid_o/up_req_ready_i     upward request handshake
//   up_req_lvl_o/up_req_id_o          upward request payload (level - 1, id)
//   up_rsp_valid_i/up_rsp_ready_o     parent wake handshake
//   up_rsp_id_i                       parent wake id
//   err_o/err_id_o                    error pulse and offending id

module fractal_sync_cc_mp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module fractal_sync_cc_mp #(
  parameter int N_PORTS    = 2,
  parameter int LVL_W      = 4,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_PORTS-1:0]       req_valid_i,
  output logic [N_PORTS-1:0]       req_ready_o,
  input  logic [N_PORTS*LVL_W-1:0] req_lvl_i,
  input  logic [N_PORTS*ID_W-1:0]  req_id_i,
  output logic                     rsp_valid_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     up_req_valid_o,
  input  logic                     up_req_ready_i,
  output logic [LVL_W-1:0]         up_req_lvl_o,
  output logic [ID_W-1:0]          up_req_id_o,
  input  logic                     up_rsp_valid_i,
  output logic                     up_rsp_ready_o,
  input  logic [ID_W-1:0]          up_rsp_id_i,
  output logic                     err_o,
  output logic [ID_W-1:0]          err_id_o
);
  localparam int RW = LVL_W + ID_W;
  localparam int NE = 2 ** ID_W;
  localparam int PW = $clog2(N_PORTS);

  logic [RW-1:0]      head [N_PORTS];
  logic [N_PORTS-1:0] in_empty, in_full, pop;
  logic               up_empty, up_full, up_push;
  logic [RW-1:0]      up_head;

  logic [N_PORTS-1:0] mask_q [NE];
  logic [N_PORTS-1:0] mask_d [NE];
  logic [LVL_W-1:0]   lvl_q [NE];
  logic [LVL_W-1:0]   lvl_d [NE];
  logic [PW-1:0]      rr_q, rr_d, gnt;
  logic               gnt_vld;
  logic               rsp_valid_q, rsp_valid_d, hold_q, hold_d, err_q, err_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d, hold_id_q, hold_id_d, err_id_q, err_id_d;
  logic [LVL_W-1:0]   hd_lvl;
  logic [ID_W-1:0]    hd_id;
  logic [N_PORTS-1:0] m, m_new;
  logic               wake_vld, par_acc;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_in
    fractal_sync_cc_mp_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (req_valid_i[p]),
      .data_i  ({req_lvl_i[p*LVL_W +: LVL_W], req_id_i[p*ID_W +: ID_W]}),
      .pop_i   (pop[p]),
      .data_o  (head[p]),
      .empty_o (in_empty[p]),
      .full_o  (in_full[p])
    );
  end

  fractal_sync_cc_mp_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_up_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (up_push),
    .data_i  ({hd_lvl - 1'b1, hd_id}),
    .pop_i   (up_req_ready_i),
    .data_o  (up_head),
    .empty_o (up_empty),
    .full_o  (up_full)
  );

  assign req_ready_o    = ~in_full;
  assign up_req_valid_o = ~up_empty;
  assign {up_req_lvl_o, up_req_id_o} = up_head;
  assign up_rsp_ready_o = ~hold_q;
  assign par_acc        = up_rsp_valid_i & ~hold_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_id_o       = rsp_id_q;
  assign err_o          = err_q;
  assign err_id_o       = err_id_q;

  // Round-robin: first non-empty head at or after rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!gnt_vld && !in_empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(idx);
      end
    end
  end

  always_comb begin
    pop      = '0;
    mask_d   = mask_q;
    lvl_d    = lvl_q;
    rr_d     = rr_q;
    err_d    = 1'b0;
    err_id_d = '0;
    wake_vld = 1'b0;
    up_push  = 1'b0;
    hd_lvl   = head[gnt][RW-1:ID_W];
    hd_id    = head[gnt][ID_W-1:0];
    m        = mask_q[hd_id];
    m_new    = m;
    m_new[gnt] = 1'b1;
    if (gnt_vld) begin
      if (hd_lvl == '0 || m[gnt] || (m != '0 && hd_lvl != lvl_q[hd_id])) begin
        pop[gnt] = 1'b1;
        err_d    = 1'b1;
        err_id_d = hd_id;
      end else if (&m_new) begin
        if (hd_lvl == LVL_W'(1)) begin
          pop[gnt]      = 1'b1;
          mask_d[hd_id] = '0;
          wake_vld      = 1'b1;
        end else if (!up_full) begin
          pop[gnt]      = 1'b1;
          mask_d[hd_id] = '0;
          up_push       = 1'b1;
        end
        // else: upward FIFO full, leave head and RF untouched and retry
      end else begin
        pop[gnt]      = 1'b1;
        mask_d[hd_id] = m_new;
        if (m == '0) lvl_d[hd_id] = hd_lvl;
      end
    end
    if (pop[gnt]) rr_d = (gnt == PW'(N_PORTS - 1)) ? '0 : gnt + 1'b1;
  end

  // Wake output: local wake wins; a parent wake colliding with it is parked
  // in the holding register and emitted on a later cycle.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    hold_d      = hold_q;
    hold_id_d   = hold_id_q;
    if (wake_vld) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = hd_id;
      if (par_acc) begin
        hold_d    = 1'b1;
        hold_id_d = up_rsp_id_i;
      end
    end else if (hold_q) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = hold_id_q;
      hold_d      = 1'b0;
    end else if (par_acc) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = up_rsp_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q      <= '{default: '0};
      lvl_q       <= '{default: '0};
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      hold_q      <= 1'b0;
      hold_id_q   <= '0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
    end else begin
      mask_q      <= mask_d;
      lvl_q       <= lvl_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      hold_q      <= hold_d;
      hold_id_q   <= hold_id_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
    end
  end
endmodule

// File: tb/tb_fractal_sync_cc_mp.sv
// tb/tb_fractal_sync_cc_mp.sv - self-checking bench for fractal_sync_cc_mp
module tb_fractal_sync_cc_mp;
  localparam int N  = 2;
  localparam int LW = 4;
  localparam int IW = 4;
  localparam int D  = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_ready_o;
  logic [N*LW-1:0] req_lvl_i;
  logic [N*IW-1:0] req_id_i;
  logic            rsp_valid_o;
  logic [IW-1:0]   rsp_id_o;
  logic            up_req_valid_o, up_req_ready_i;
  logic [LW-1:0]   up_req_lvl_o;
  logic [IW-1:0]   up_req_id_o;
  logic            up_rsp_valid_i, up_rsp_ready_o;
  logic [IW-1:0]   up_rsp_id_i;
  logic            err_o;
  logic [IW-1:0]   err_id_o;

  always #5 clk = ~clk;

  fractal_sync_cc_mp #(.N_PORTS(N), .LVL_W(LW), .ID_W(IW), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_lvl_i(req_lvl_i), .req_id_i(req_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
    .up_req_valid_o(up_req_valid_o), .up_req_ready_i(up_req_ready_i),
    .up_req_lvl_o(up_req_lvl_o), .up_req_id_o(up_req_id_o),
    .up_rsp_valid_i(up_rsp_valid_i), .up_rsp_ready_o(up_rsp_ready_o),
    .up_rsp_id_i(up_rsp_id_i),
    .err_o(err_o), .err_id_o(err_id_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int wake_id_q[$], wake_cyc_q[$], err_id_q[$];
  int up_lvl_q[$], up_id_q[$], pacc_cyc_q[$];
  int pq [N][$];
  int pend_q[$];
  bit auto_stim   = 0;
  bit auto_parent = 0;
  int stim_pct    = 100;
  int rdy_pct     = 100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    wake_id_q.delete(); wake_cyc_q.delete(); err_id_q.delete();
    up_lvl_q.delete(); up_id_q.delete(); pacc_cyc_q.delete(); pend_q.delete();
  endtask

  // Called at a negedge with inputs set: records the handshakes the next
  // posedge will perform, then samples the registered pulses after it.
  task automatic tick();
    if (auto_stim) begin
      for (int p = 0; p < N; p++) begin
        if (pq[p].size() > 0 && $urandom_range(99) < stim_pct) begin
          req_valid_i[p] = 1'b1;
          req_lvl_i[p*LW +: LW] = LW'(pq[p][0] / 256);
          req_id_i[p*IW +: IW]  = IW'(pq[p][0] % 256);
        end else begin
          req_valid_i[p] = 1'b0;
        end
      end
    end
    if (auto_parent) begin
      up_req_ready_i = ($urandom_range(99) < rdy_pct);
      if (pend_q.size() > 0 && $urandom_range(99) < rdy_pct) begin
        up_rsp_valid_i = 1'b1;
        up_rsp_id_i    = IW'(pend_q[0]);
      end else begin
        up_rsp_valid_i = 1'b0;
      end
    end
    #1;
    if (!rst_i) begin
      for (int p = 0; p < N; p++)
        if (auto_stim && req_valid_i[p] && req_ready_o[p]) void'(pq[p].pop_front());
      if (up_req_valid_o && up_req_ready_i) begin
        up_lvl_q.push_back(int'(up_req_lvl_o));
        up_id_q.push_back(int'(up_req_id_o));
        if (auto_parent) pend_q.push_back(int'(up_req_id_o));
      end
      if (up_rsp_valid_i && up_rsp_ready_o) begin
        pacc_cyc_q.push_back(cyc);
        if (auto_parent) void'(pend_q.pop_front());
      end
    end
    @(negedge clk);
    cyc++;
    if (rsp_valid_o) begin
      wake_id_q.push_back(int'(rsp_id_o));
      wake_cyc_q.push_back(cyc);
    end
    if (err_o) err_id_q.push_back(int'(err_id_o));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int p, input int lvl, input int id);
    req_valid_i[p] = 1'b1;
    req_lvl_i[p*LW +: LW] = LW'(lvl);
    req_id_i[p*IW +: IW]  = IW'(id);
  endtask

  task automatic do_reset();
    auto_stim = 0; auto_parent = 0;
    req_valid_i = '0; up_req_ready_i = 0; up_rsp_valid_i = 0;
    rst_i = 1'b1;
    ticks(2);
    rst_i = 1'b0;
    clear_logs();
  endtask

  function automatic int find(input int q[$], input int v);
    for (int i = 0; i < q.size(); i++) if (q[i] == v) return i;
    return -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, k, idx;
    int ids[16];
    int lvls[16];
    int exp_wake[$], exp_up[$], exp_err[$];
    int order[$];
    bit done;

    rst_i = 1'b1; req_valid_i = '0; req_lvl_i = '0; req_id_i = '0;
    up_req_ready_i = 0; up_rsp_valid_i = 0; up_rsp_id_i = '0;
    @(negedge clk);
    ticks(2);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_id", rsp_id_o, 0);
    check("rst_up_valid", up_req_valid_o, 0);
    check("rst_up_lvl_id", {up_req_lvl_o, up_req_id_o}, 0);
    check("rst_err", {err_o, err_id_o}, 0);
    check("rst_up_rsp_ready", up_rsp_ready_o, 1);
    check("rst_req_ready", req_ready_o, 2'b11);
    do_reset();

    // Local wake across two cycles
    t0 = cyc;
    set_req(0, 1, 3); tick();
    req_valid_i = '0; set_req(1, 1, 3); tick();
    req_valid_i = '0; ticks(5);
    check("lw_count", wake_id_q.size(), 1);
    if (wake_id_q.size() > 0) begin
      check("lw_id", wake_id_q[0], 3);
      check("lw_cycle", wake_cyc_q[0], t0 + 3);
    end
    check("lw_no_up", up_id_q.size(), 0);
    clear_logs();
    set_req(1, 1, 3); tick();
    req_valid_i = '0; set_req(0, 1, 3); tick();
    req_valid_i = '0; ticks(5);
    check("lw_reuse_count", wake_id_q.size(), 1);
    check("lw_reuse_err", err_id_q.size(), 0);
    clear_logs();

    // Forwarding with back-pressure, then parent wake
    set_req(0, 3, 5); set_req(1, 3, 5); tick();
    req_valid_i = '0;
    k = 0;
    while (!up_req_valid_o && k < 10) begin tick(); k++; end
    check("fw_up_valid", up_req_valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      check("fw_hold_payload", {up_req_lvl_o, up_req_id_o}, {4'd2, 4'd5});
      tick();
    end
    up_req_ready_i = 1; tick(); up_req_ready_i = 0;
    check("fw_up_count", up_id_q.size(), 1);
    check("fw_up_gone", up_req_valid_o, 0);
    up_rsp_valid_i = 1; up_rsp_id_i = 5;
    check("fw_par_ready", up_rsp_ready_o, 1);
    tick(); up_rsp_valid_i = 0; ticks(3);
    check("fw_wake_count", wake_id_q.size(), 1);
    if (wake_id_q.size() > 0 && pacc_cyc_q.size() > 0) begin
      check("fw_wake_id", wake_id_q[0], 5);
      check("fw_wake_cycle", wake_cyc_q[0], pacc_cyc_q[0] + 1);
    end
    clear_logs();

    // Duplicate arrival
    set_req(0, 1, 2); tick(); tick(); req_valid_i = '0; ticks(4);
    check("dup_err_count", err_id_q.size(), 1);
    if (err_id_q.size() > 0) check("dup_err_id", err_id_q[0], 2);
    check("dup_no_wake", wake_id_q.size(), 0);
    set_req(1, 1, 2); tick(); req_valid_i = '0; ticks(4);
    check("dup_wake_count", wake_id_q.size(), 1);
    if (wake_id_q.size() > 0) check("dup_wake_id", wake_id_q[0], 2);
    clear_logs();

    // Level mismatch and level zero
    set_req(0, 2, 7); set_req(1, 1, 7); tick();
    req_valid_i = '0; set_req(0, 0, 1); tick();
    req_valid_i = '0; ticks(5);
    check("mm_err_count", err_id_q.size(), 2);
    check("mm_err_id7", find(err_id_q, 7) >= 0, 1);
    check("mm_err_id1", find(err_id_q, 1) >= 0, 1);
    check("mm_no_wake", wake_id_q.size() + up_id_q.size(), 0);
    do_reset();

    // Upward FIFO full stall, input back-pressure, ordered drain
    for (int p = 0; p < N; p++) for (int i = 10; i < 15; i++) pq[p].push_back(2 * 256 + i);
    auto_stim = 1; auto_parent = 1; stim_pct = 100; rdy_pct = 0;
    ticks(25);
    check("st_req_ready", req_ready_o, 2'b00);
    check("st_up_valid", up_req_valid_o, 1);
    check("st_up_head", {up_req_lvl_o, up_req_id_o}, {4'd1, 4'd10});
    check("st_no_up_hs", up_id_q.size(), 0);
    rdy_pct = 100;
    k = 0;
    while (wake_id_q.size() < 5 && k < 200) begin tick(); k++; end
    check("st_drain_done", wake_id_q.size(), 5);
    check("st_up_count", up_id_q.size(), 5);
    for (int i = 0; i < 5 && i < up_id_q.size(); i++) begin
      check("st_up_order", up_id_q[i], 10 + i);
      check("st_up_lvl", up_lvl_q[i], 1);
    end
    check("st_no_err", err_id_q.size(), 0);
    do_reset();

    // Local wake id4 collides with parent wake id9
    t0 = cyc;
    set_req(0, 1, 4); tick();
    req_valid_i = '0; set_req(1, 1, 4); tick();
    req_valid_i = '0; up_rsp_valid_i = 1; up_rsp_id_i = 9;
    check("col_par_ready", up_rsp_ready_o, 1);
    tick(); up_rsp_valid_i = 0;
    check("col_hold_ready", up_rsp_ready_o, 0);
    ticks(4);
    check("col_wake_count", wake_id_q.size(), 2);
    if (wake_id_q.size() >= 2) begin
      check("col_first", {wake_id_q[0], wake_cyc_q[0]}, {32'd4, 32'(t0 + 3)});
      check("col_second", {wake_id_q[1], wake_cyc_q[1]}, {32'd9, 32'(t0 + 4)});
    end
    check("col_ready_back", up_rsp_ready_o, 1);
    clear_logs();

    // Reset mid-barrier
    set_req(0, 1, 6); tick(); req_valid_i = '0; ticks(2);
    rst_i = 1; tick();
    check("mr_outputs", {rsp_valid_o, up_req_valid_o, err_o, rsp_id_o, err_id_o, up_req_lvl_o, up_req_id_o}, 0);
    check("mr_readies", {req_ready_o, up_rsp_ready_o}, 3'b111);
    tick(); rst_i = 0; clear_logs();
    set_req(1, 1, 6); tick(); req_valid_i = '0; ticks(5);
    check("mr_no_wake", wake_id_q.size(), 0);
    set_req(0, 1, 6); tick(); req_valid_i = '0; ticks(5);
    check("mr_fresh_wake", wake_id_q.size(), 1);
    do_reset();

    // Randomized barriers against a set-based reference model
    for (int i = 0; i < 16; i++) ids[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(i); tmp = ids[i]; ids[i] = ids[j]; ids[j] = tmp;
    end
    for (int b = 0; b < 10; b++) begin
      lvls[b] = $urandom_range(1, 3);
      exp_wake.push_back(ids[b]);
      if (lvls[b] > 1) exp_up.push_back((lvls[b] - 1) * 256 + ids[b]);
    end
    for (int p = 0; p < N; p++) begin
      order.delete();
      for (int b = 0; b < 10; b++) order.insert($urandom_range(order.size()), b);
      foreach (order[i]) begin
        if ($urandom_range(3) == 0) begin
          int eid;
          eid = $urandom_range(15);
          pq[p].push_back(eid);
          exp_err.push_back(eid);
        end
        pq[p].push_back(lvls[order[i]] * 256 + ids[order[i]]);
      end
    end
    auto_stim = 1; auto_parent = 1; stim_pct = 60; rdy_pct = 60;
    k = 0; done = 0;
    while (!done && k < 4000) begin
      tick(); k++;
      done = (pq[0].size() == 0 && pq[1].size() == 0 && wake_id_q.size() >= 10 &&
              err_id_q.size() >= exp_err.size());
    end
    ticks(5);
    check("rnd_complete", done, 1);
    check("rnd_wake_count", wake_id_q.size(), 10);
    check("rnd_up_count", up_id_q.size(), exp_up.size());
    check("rnd_err_count", err_id_q.size(), exp_err.size());
    foreach (wake_id_q[i]) begin
      idx = find(exp_wake, wake_id_q[i]);
      check("rnd_wake_expected", idx >= 0, 1);
      if (idx >= 0) exp_wake.delete(idx);
    end
    foreach (up_id_q[i]) begin
      idx = find(exp_up, up_lvl_q[i] * 256 + up_id_q[i]);
      check("rnd_up_expected", idx >= 0, 1);
      if (idx >= 0) exp_up.delete(idx);
    end
    foreach (err_id_q[i]) begin
      idx = find(exp_err, err_id_q[i]);
      check("rnd_err_expected", idx >= 0, 1);
      if (idx >= 0) exp_err.delete(idx);
    end
    check("rnd_wake_left", exp_wake.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
